// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline.
// Handles post-reset init, load-use bubbles, taken-branch flushes and
// memory-wait freezes with a timeout into a sticky error state.
module pipe_hazard_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             en_if2id,
  output logic             en_id2ex,
  output logic             en_ex2mem,
  output logic             en_mem2wb,
  output logic             flush_if2id,
  output logic             flush_id2ex,
  output logic             flush_ex2mem,
  output logic             flush_mem2wb,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    init_cnt_q, init_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             err_q, err_d;
  logic             load_use;
  logic             mem_stall;
  logic             run_decode;

  assign load_use  = ex_memread & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign mem_stall = mem_req & ~mem_ready;

  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;

  // Next-state and output decode from current state and hazard inputs
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    err_d        = err_q;
    run_decode   = 1'b0;
    pc_en        = 1'b0;
    en_if2id     = 1'b0;
    en_id2ex     = 1'b0;
    en_ex2mem    = 1'b0;
    en_mem2wb    = 1'b0;
    flush_if2id  = 1'b0;
    flush_id2ex  = 1'b0;
    flush_ex2mem = 1'b0;
    flush_mem2wb = 1'b0;

    case (state_q)
      S_INIT: begin
        // Clock zeros into every stage register while the PC holds.
        en_if2id     = 1'b1;
        en_id2ex     = 1'b1;
        en_ex2mem    = 1'b1;
        en_mem2wb    = 1'b1;
        flush_if2id  = 1'b1;
        flush_id2ex  = 1'b1;
        flush_ex2mem = 1'b1;
        flush_mem2wb = 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = S_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      S_RUN: begin
        if (mem_stall) begin
          // Freeze everything; branch/load-use inputs stay held upstream.
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WW'(1);
        end else begin
          run_decode = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready || !mem_req) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
          run_decode = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_ERROR: begin
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase

    if (run_decode) begin
      pc_en     = 1'b1;
      en_if2id  = 1'b1;
      en_id2ex  = 1'b1;
      en_ex2mem = 1'b1;
      en_mem2wb = 1'b1;
      if (ex_branch_taken) begin
        // The hazarding instruction is squashed, so no bubble is needed.
        flush_if2id = 1'b1;
        flush_id2ex = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        en_if2id    = 1'b0;
        flush_id2ex = 1'b1;
      end
    end

    if (((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !pc_en && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // While reset is held, keep every stage cleared and nothing advancing.
    if (!rst_n) begin
      pc_en        = 1'b0;
      en_if2id     = 1'b0;
      en_id2ex     = 1'b0;
      en_ex2mem    = 1'b0;
      en_mem2wb    = 1'b0;
      flush_if2id  = 1'b1;
      flush_id2ex  = 1'b1;
      flush_ex2mem = 1'b1;
      flush_mem2wb = 1'b1;
    end
  end

  // State and counter registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each stimulus cycle pushes its
// expected outputs, which are popped and compared at the falling edge.
module tb_pipe_hazard_ctrl;

  // Output vector order: {pc_en, en x4 (if2id..mem2wb), flush x4, err}
  localparam logic [9:0] RST_V  = 10'b0_0000_1111_0;
  localparam logic [9:0] INIT_V = 10'b0_1111_1111_0;
  localparam logic [9:0] RUN_V  = 10'b1_1111_0000_0;
  localparam logic [9:0] STL_V  = 10'b0_0000_0000_0;
  localparam logic [9:0] LU_V   = 10'b0_0111_0100_0;
  localparam logic [9:0] BR_V   = 10'b1_1111_1100_0;
  localparam logic [9:0] ERR_V  = 10'b0_0000_0000_1;

  typedef struct packed {
    logic       rn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       mrd;
    logic [4:0] ert;
    logic       br;
    logic       req;
    logic       rdy;
    logic [9:0] v;
    logic       cnt;
  } stim_t;

  typedef struct packed {
    logic [9:0]  v;
    logic [15:0] c16;
    logic [3:0]  c4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic        pc_en, en_if2id, en_id2ex, en_ex2mem, en_mem2wb;
  logic        flush_if2id, flush_id2ex, flush_ex2mem, flush_mem2wb, err;
  logic [15:0] stall_cnt;
  logic        s_pc_en, s_en_if2id, s_en_id2ex, s_en_ex2mem, s_en_mem2wb;
  logic        s_flush_if2id, s_flush_id2ex, s_flush_ex2mem, s_flush_mem2wb, s_err;
  logic [3:0]  s_stall_cnt;
  logic [9:0]  obs, obs_s;

  exp_t        sb[$];
  logic [15:0] exp_c16;
  logic [3:0]  exp_c4;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en),
    .en_if2id(en_if2id), .en_id2ex(en_id2ex), .en_ex2mem(en_ex2mem), .en_mem2wb(en_mem2wb),
    .flush_if2id(flush_if2id), .flush_id2ex(flush_id2ex),
    .flush_ex2mem(flush_ex2mem), .flush_mem2wb(flush_mem2wb),
    .err(err), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(s_pc_en),
    .en_if2id(s_en_if2id), .en_id2ex(s_en_id2ex), .en_ex2mem(s_en_ex2mem),
    .en_mem2wb(s_en_mem2wb), .flush_if2id(s_flush_if2id), .flush_id2ex(s_flush_id2ex),
    .flush_ex2mem(s_flush_ex2mem), .flush_mem2wb(s_flush_mem2wb),
    .err(s_err), .stall_cnt(s_stall_cnt)
  );

  assign obs   = {pc_en, en_if2id, en_id2ex, en_ex2mem, en_mem2wb,
                  flush_if2id, flush_id2ex, flush_ex2mem, flush_mem2wb, err};
  assign obs_s = {s_pc_en, s_en_if2id, s_en_id2ex, s_en_ex2mem, s_en_mem2wb,
                  s_flush_if2id, s_flush_id2ex, s_flush_ex2mem, s_flush_mem2wb, s_err};

  function automatic stim_t mk(logic rn, logic [4:0] rs, logic [4:0] rt, logic urt,
                               logic mrd, logic [4:0] ert, logic br, logic req,
                               logic rdy, logic [9:0] v, logic cnt);
    stim_t s;
    s = '{rn, rs, rt, urt, mrd, ert, br, req, rdy, v, cnt};
    return s;
  endfunction

  // Drive one cycle, record its expected outputs, wait for the sample edge
  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    rst_n           = s.rn;
    id_rs           = s.rs;
    id_rt           = s.rt;
    id_uses_rt      = s.urt;
    ex_memread      = s.mrd;
    ex_rt           = s.ert;
    ex_branch_taken = s.br;
    mem_req         = s.req;
    mem_ready       = s.rdy;
    if (!s.rn) begin
      exp_c16 = '0;
      exp_c4  = '0;
    end
    sb.push_back('{s.v, exp_c16, exp_c4});
    if (s.cnt) begin
      if (exp_c16 != 16'hffff) exp_c16 = exp_c16 + 16'd1;
      if (exp_c4 != 4'hf) exp_c4 = exp_c4 + 4'd1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t q[$];
    exp_t  e;
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RST_V, 0));
    for (int k = 0; k < 4; k++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, INIT_V, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RUN_V, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RUN_V, 0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      checks += 4;
      if (obs !== e.v) begin errors++; $display("FAIL reset[%0d] outputs got=%b exp=%b", i, obs, e.v); end
      if (obs_s !== e.v) begin errors++; $display("FAIL reset[%0d] outputs_w4 got=%b exp=%b", i, obs_s, e.v); end
      if (stall_cnt !== e.c16) begin errors++; $display("FAIL reset[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, e.c16); end
      if (s_stall_cnt !== e.c4) begin errors++; $display("FAIL reset[%0d] stall_cnt_w4 got=%0d exp=%0d", i, s_stall_cnt, e.c4); end
      $display("reset[%0d] outputs=%b stall_cnt=%0d", i, obs, stall_cnt);
    end
  endtask

  task automatic test_load_use();
    stim_t q[$];
    exp_t  e;
    q.push_back(mk(1, 8, 0, 0, 1, 8, 0, 0, 0, LU_V, 1));   // rs match
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RUN_V, 0));
    q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, RUN_V, 0));  // r0 never hazards
    q.push_back(mk(1, 3, 9, 1, 1, 9, 0, 0, 0, LU_V, 1));   // rt match, rt used
    q.push_back(mk(1, 3, 9, 0, 1, 9, 0, 0, 0, RUN_V, 0));  // rt match, rt unused
    q.push_back(mk(1, 8, 0, 0, 0, 8, 0, 0, 0, RUN_V, 0));  // not a load
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RUN_V, 0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      checks += 4;
      if (obs !== e.v) begin errors++; $display("FAIL load_use[%0d] outputs got=%b exp=%b", i, obs, e.v); end
      if (obs_s !== e.v) begin errors++; $display("FAIL load_use[%0d] outputs_w4 got=%b exp=%b", i, obs_s, e.v); end
      if (stall_cnt !== e.c16) begin errors++; $display("FAIL load_use[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, e.c16); end
      if (s_stall_cnt !== e.c4) begin errors++; $display("FAIL load_use[%0d] stall_cnt_w4 got=%0d exp=%0d", i, s_stall_cnt, e.c4); end
      $display("load_use[%0d] outputs=%b stall_cnt=%0d", i, obs, stall_cnt);
    end
  endtask

  task automatic test_branch();
    stim_t q[$];
    exp_t  e;
    q.push_back(mk(1, 8, 0, 0, 1, 8, 1, 0, 0, BR_V, 0));   // branch beats load-use
    q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, BR_V, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RUN_V, 0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      checks += 4;
      if (obs !== e.v) begin errors++; $display("FAIL branch[%0d] outputs got=%b exp=%b", i, obs, e.v); end
      if (obs_s !== e.v) begin errors++; $display("FAIL branch[%0d] outputs_w4 got=%b exp=%b", i, obs_s, e.v); end
      if (stall_cnt !== e.c16) begin errors++; $display("FAIL branch[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, e.c16); end
      if (s_stall_cnt !== e.c4) begin errors++; $display("FAIL branch[%0d] stall_cnt_w4 got=%0d exp=%0d", i, s_stall_cnt, e.c4); end
      $display("branch[%0d] outputs=%b stall_cnt=%0d", i, obs, stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    stim_t q[$];
    exp_t  e;
    for (int k = 0; k < 3; k++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, STL_V, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, RUN_V, 0));  // ready: full enable
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RUN_V, 0));
    q.push_back(mk(1, 8, 0, 0, 1, 8, 0, 1, 0, STL_V, 1));  // mem stall beats load-use
    q.push_back(mk(1, 8, 0, 0, 1, 8, 0, 1, 1, LU_V, 1));   // load-use evaluated on ready
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, STL_V, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, BR_V, 0));   // req dropped = ready
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RUN_V, 0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      checks += 4;
      if (obs !== e.v) begin errors++; $display("FAIL mem_wait[%0d] outputs got=%b exp=%b", i, obs, e.v); end
      if (obs_s !== e.v) begin errors++; $display("FAIL mem_wait[%0d] outputs_w4 got=%b exp=%b", i, obs_s, e.v); end
      if (stall_cnt !== e.c16) begin errors++; $display("FAIL mem_wait[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, e.c16); end
      if (s_stall_cnt !== e.c4) begin errors++; $display("FAIL mem_wait[%0d] stall_cnt_w4 got=%0d exp=%0d", i, s_stall_cnt, e.c4); end
      $display("mem_wait[%0d] outputs=%b stall_cnt=%0d", i, obs, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    stim_t q[$];
    exp_t  e;
    for (int k = 0; k < 21; k++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, STL_V, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, RUN_V, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RUN_V, 0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      checks += 4;
      if (obs !== e.v) begin errors++; $display("FAIL saturate[%0d] outputs got=%b exp=%b", i, obs, e.v); end
      if (obs_s !== e.v) begin errors++; $display("FAIL saturate[%0d] outputs_w4 got=%b exp=%b", i, obs_s, e.v); end
      if (stall_cnt !== e.c16) begin errors++; $display("FAIL saturate[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, e.c16); end
      if (s_stall_cnt !== e.c4) begin errors++; $display("FAIL saturate[%0d] stall_cnt_w4 got=%0d exp=%0d", i, s_stall_cnt, e.c4); end
      $display("saturate[%0d] outputs=%b stall_cnt=%0d stall_cnt_w4=%0d", i, obs, stall_cnt, s_stall_cnt);
    end
  endtask

  task automatic test_timeout();
    stim_t q[$];
    exp_t  e;
    for (int k = 0; k < 64; k++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, STL_V, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, ERR_V, 0));  // ready no longer helps
    q.push_back(mk(1, 8, 0, 0, 1, 8, 1, 0, 0, ERR_V, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, ERR_V, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RST_V, 0));  // reset pulse mid-ERROR
    for (int k = 0; k < 4; k++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, INIT_V, 0));
    q.push_back(mk(1, 5, 0, 0, 1, 5, 0, 0, 0, LU_V, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RUN_V, 0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      checks += 4;
      if (obs !== e.v) begin errors++; $display("FAIL timeout[%0d] outputs got=%b exp=%b", i, obs, e.v); end
      if (obs_s !== e.v) begin errors++; $display("FAIL timeout[%0d] outputs_w4 got=%b exp=%b", i, obs_s, e.v); end
      if (stall_cnt !== e.c16) begin errors++; $display("FAIL timeout[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, e.c16); end
      if (s_stall_cnt !== e.c4) begin errors++; $display("FAIL timeout[%0d] stall_cnt_w4 got=%0d exp=%0d", i, s_stall_cnt, e.c4); end
      $display("timeout[%0d] outputs=%b stall_cnt=%0d", i, obs, stall_cnt);
    end
  endtask

  initial begin
    rst_n           = 1'b1;
    id_rs           = '0;
    id_rt           = '0;
    id_uses_rt      = 1'b0;
    ex_memread      = 1'b0;
    ex_rt           = '0;
    ex_branch_taken = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b0;
    exp_c16         = '0;
    exp_c4          = '0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_saturation();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the PC enable, plus the en_reg and synchronous-clear (rst) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles three conditions:
  - load-use hazards, by inserting one bubble;
  - taken branches, by flushing two stages;
  - multi-cycle data-memory accesses, by freezing the pipeline under a ready handshake with a timeout.
- Also provides post-reset pipeline initialisation and a stall statistics counter.

Parameters:
INIT_CYCLES, 4, cycles after reset release during which all pipeline registers are held cleared
MEM_TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before entering ERROR (>=2)
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_memread  in  1  instruction in EX is a load
ex_rt  in  5  destination of the load in EX
ex_branch_taken  in  1  branch resolved taken in EX this cycle
mem_req  in  1  MEM stage issues a data-memory access this cycle
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
en_if2id  out  1  IF/ID en_reg
en_id2ex  out  1  ID/EX en_reg
en_ex2mem  out  1  EX/MEM en_reg
en_mem2wb  out  1  MEM/WB en_reg
flush_if2id  out  1  IF/ID synchronous clear
flush_id2ex  out  1  ID/EX synchronous clear
flush_ex2mem  out  1  EX/MEM synchronous clear
flush_mem2wb  out  1  MEM/WB synchronous clear
err  out  1  memory timeout, sticky
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0 while in RUN or MEM_WAIT

Behaviour:
- Reset is asynchronous and active-low.
- State register: INIT, RUN, MEM_WAIT, ERROR.
- Registered state: the state itself, init_cnt, wait_cnt, stall_cnt and err.
- Outputs are a combinational decode of state and current inputs.

rst_n low:
- Values: state=INIT, init_cnt=0, wait_cnt=0, stall_cnt=0, err=0.
- Outputs: all en_*=0, pc_en=0, all flush_*=1.
- Reset asserted mid-operation aborts any wait immediately.

INIT:
- Outputs: all flush_*=1, all en_*=1, pc_en=0.
- init_cnt increments each cycle. When init_cnt==INIT_CYCLES-1, go to RUN.

Hazard terms:
- load_use = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt))
- mem_stall = mem_req & ~mem_ready

RUN:
- Default: all en=1, pc_en=1, all flush=0.
- mem_stall: highest priority.
  - Outputs: all en=0, pc_en=0, no flush.
  - Next state MEM_WAIT, wait_cnt=1.
  - Branch and load-use terms are ignored this cycle; their inputs are held by the frozen registers.
- else ex_branch_taken:
  - flush_if2id=1, flush_id2ex=1, pc_en=1 (PC loads the branch target).
  - Overrides load_use, because the hazarding instruction is squashed.
- else load_use:
  - pc_en=0, en_if2id=0, flush_id2ex=1 (bubble).
  - en_ex2mem=1, en_mem2wb=1.
  - Exactly one bubble per hazard, since the load leaves EX next cycle.

MEM_WAIT:
- mem_ready=1:
  - Outputs are the RUN decode with mem_stall forced 0.
  - Branch and load-use are evaluated normally this cycle.
  - Next state RUN, wait_cnt=0.
- mem_ready=0:
  - Outputs: all en=0, pc_en=0.
  - wait_cnt increments.
  - If wait_cnt==MEM_TIMEOUT-1: go to ERROR, err=1.
- mem_req dropping while in MEM_WAIT is treated as mem_ready=1.

ERROR:
- Outputs: all en=0, pc_en=0, flush=0, err=1.
- Left only by reset.

stall_cnt:
- +1 on each cycle in RUN or MEM_WAIT with pc_en=0.
- Saturates at all-ones; no wrap.

Test Plan:
- Reset release with INIT_CYCLES=4 -> flush_* high and pc_en low for exactly 4 cycles; RUN on the 5th with all en=1, flush=0; stall_cnt=0.
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 for one cycle -> pc_en=0, en_if2id=0, flush_id2ex=1 for one cycle; stall_cnt=1. Repeat with ex_rt=0 -> no stall.
- ex_branch_taken=1 coinciding with load_use=1 -> flush_if2id=flush_id2ex=1, pc_en=1; stall_cnt unchanged.
- mem_req=1 with mem_ready low for 3 cycles, then high -> all en=0 for 3 cycles; full enable in the cycle mem_ready rises; stall_cnt=3.
- mem_ready held low with MEM_TIMEOUT=64 -> ERROR after 64 stall cycles; err=1 sticky. Pulse rst_n low mid-ERROR -> err=0, state INIT.
- Force 2^CNT_W+5 stall cycles (CNT_W=4) -> stall_cnt stays at 15.
